// File: rtl/npu_mac_sequencer.sv
// rtl/npu_mac_sequencer.sv - time-multiplexes one 4-lane int8 dot-product unit across a fully-connected layer
module npu_mac_sequencer #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 4,
  parameter int ACC_W       = 20,
  parameter int RELU        = 1,
  localparam int C     = NUM_INPUTS / 4,
  localparam int WA_W  = (NUM_NEURONS * C > 1) ? $clog2(NUM_NEURONS * C) : 1,
  localparam int XA_W  = (C > 1) ? $clog2(C) : 1,
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [WA_W-1:0]  w_addr,
  output logic [XA_W-1:0]  x_addr,
  input  logic [31:0]      w_rdata,
  input  logic [31:0]      x_rdata,
  output logic [31:0]      pe_w,
  output logic [31:0]      pe_x,
  input  logic [15:0]      pe_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_t                   r_state;
  logic [2:0]               r_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_pe_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [15:0]              w_result;

  // r_vld[2] marks the cycle pe_result belongs to a fetched chunk
  always_comb begin
    w_pe_ext   = {{(ACC_W-16){pe_result[15]}}, pe_result};
    w_acc_next = r_vld[2] ? r_acc + w_pe_ext : r_acc;
    if (w_acc_next > SAT_MAX)
      w_result = 16'h7fff;
    else if (w_acc_next < SAT_MIN)
      w_result = 16'h8000;
    else
      w_result = w_acc_next[15:0];
    if (RELU != 0 && w_result[15])
      w_result = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_vld     <= '0;
      r_acc     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
      pe_w      <= '0;
      pe_x      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      r_vld <= {r_vld[1:0], mem_rd_en};
      pe_w  <= r_vld[0] ? w_rdata : '0;
      pe_x  <= r_vld[0] ? x_rdata : '0;
      r_acc <= w_acc_next;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            w_addr    <= '0;
            x_addr    <= '0;
            out_idx   <= '0;
            r_acc     <= '0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (x_addr == XA_W'(C - 1)) begin
            mem_rd_en <= 1'b0;
            r_state   <= S_DRAIN;
          end else begin
            w_addr <= w_addr + WA_W'(1);
            x_addr <= x_addr + XA_W'(1);
          end
        end
        S_DRAIN: begin
          // the final chunk is being summed this cycle; w_result already includes it
          if (r_vld[1:0] == 2'b00) begin
            out_valid <= 1'b1;
            out_data  <= w_result;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_idx == IDX_W'(NUM_NEURONS - 1)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              out_idx   <= out_idx + IDX_W'(1);
              w_addr    <= w_addr + WA_W'(1);
              x_addr    <= '0;
              mem_rd_en <= 1'b1;
              r_acc     <= '0;
              r_state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// tb/tb_npu_mac_sequencer.sv - scoreboard bench for npu_mac_sequencer, RELU=0 and RELU=1 instances in lockstep
module tb_npu_mac_sequencer;

  typedef struct {
    int          idx;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;

  logic        busy_a, done_a, mem_rd_en_a, out_valid_a;
  logic [3:0]  w_addr_a;
  logic [1:0]  x_addr_a, out_idx_a;
  logic [31:0] w_rdata_a, x_rdata_a, pe_w_a, pe_x_a;
  logic [15:0] pe_result_a, out_data_a;

  logic        busy_b, done_b, mem_rd_en_b, out_valid_b;
  logic [3:0]  w_addr_b;
  logic [1:0]  x_addr_b, out_idx_b;
  logic [31:0] w_rdata_b, x_rdata_b, pe_w_b, pe_x_b;
  logic [15:0] pe_result_b, out_data_b;

  logic [31:0] wmem [16];
  logic [31:0] xmem [4];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   s = 0;
  int   hs_q[$];
  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npu_mac_sequencer #(.NUM_INPUTS(16), .NUM_NEURONS(4), .ACC_W(20), .RELU(0)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .mem_rd_en(mem_rd_en_a), .w_addr(w_addr_a), .x_addr(x_addr_a),
    .w_rdata(w_rdata_a), .x_rdata(x_rdata_a), .pe_w(pe_w_a), .pe_x(pe_x_a),
    .pe_result(pe_result_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_idx(out_idx_a)
  );

  npu_mac_sequencer #(.NUM_INPUTS(16), .NUM_NEURONS(4), .ACC_W(20), .RELU(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .mem_rd_en(mem_rd_en_b), .w_addr(w_addr_b), .x_addr(x_addr_b),
    .w_rdata(w_rdata_b), .x_rdata(x_rdata_b), .pe_w(pe_w_b), .pe_x(pe_x_b),
    .pe_result(pe_result_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_idx(out_idx_b)
  );

  function automatic logic [15:0] dot4(input logic [31:0] w, input logic [31:0] x);
    logic signed [15:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++)
      acc = acc + $signed(w[8*i +: 8]) * $signed(x[8*i +: 8]);
    return acc;
  endfunction

  // dot-product unit and synchronous memories, one copy per instance
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_result_a <= '0;
      pe_result_b <= '0;
    end else begin
      pe_result_a <= dot4(pe_w_a, pe_x_a);
      pe_result_b <= dot4(pe_w_b, pe_x_b);
    end
  end

  always @(posedge clk) begin
    if (mem_rd_en_a) begin
      w_rdata_a <= wmem[w_addr_a];
      x_rdata_a <= xmem[x_addr_a];
    end
    if (mem_rd_en_b) begin
      w_rdata_b <= wmem[w_addr_b];
      x_rdata_b <= xmem[x_addr_b];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid_a && out_ready) begin
        hs_q.push_back(cyc);
        if (sbq.size() == 0) begin
          check("sb_underflow", 64'(sbq.size()), 64'd1);
        end else begin
          mon_e = sbq.pop_front();
          check("data_relu0", out_data_a, mon_e.d0);
          check("data_relu1", out_data_b, mon_e.d1);
          check("idx_relu0", out_idx_a, 64'(mon_e.idx));
          check("idx_relu1", out_idx_b, 64'(mon_e.idx));
          check("valid_relu1", out_valid_b, 64'd1);
        end
      end
    end
  end

  task automatic reset_checks(input string name);
    check({name, "_outs_a"}, {busy_a, done_a, mem_rd_en_a, out_valid_a, w_addr_a, x_addr_a, out_data_a, out_idx_a}, 64'd0);
    check({name, "_pe_a"}, {pe_w_a, pe_x_a}, 64'd0);
    check({name, "_outs_b"}, {busy_b, done_b, mem_rd_en_b, out_valid_b, w_addr_b, x_addr_b, out_data_b, out_idx_b}, 64'd0);
    check({name, "_pe_b"}, {pe_w_b, pe_x_b}, 64'd0);
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                      input logic [31:0] w3, input logic [31:0] x);
    for (int c = 0; c < 4; c++) begin
      wmem[c]      = w0;
      wmem[4 + c]  = w1;
      wmem[8 + c]  = w2;
      wmem[12 + c] = w3;
      xmem[c]      = x;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt < 1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_count", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    reset = 1'b0;

    // all ones, continuous ready, plus an ignored start during neuron 1 fetch
    load(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    for (int i = 0; i < 4; i++) sbq.push_back('{i, 16'd16, 16'd16});
    out_ready = 1'b1;
    hs_q.delete();
    done_cnt = 0;
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy_a, 64'd1);
    check("first_fetch_rd", mem_rd_en_a, 64'd1);
    check("first_fetch_waddr", w_addr_a, 64'd0);
    while (cyc < s + 10) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    check("t1_results", 64'(hs_q.size()), 64'd4);
    if (hs_q.size() == 4) begin
      check("first_valid_latency", 64'(hs_q[0] - s), 64'd8);
      for (int i = 1; i < 4; i++) check("neuron_spacing", 64'(hs_q[i] - hs_q[i-1]), 64'd8);
      check("done_after_last_hs", 64'(done_cyc - hs_q[3]), 64'd1);
    end
    repeat (12) @(negedge clk);
    check("single_done", 64'(done_cnt), 64'd1);
    check("idle_not_busy", busy_a, 64'd0);
    check("t1_sb_empty", 64'(sbq.size()), 64'd0);

    // saturation, relu, and a ready stall on neuron 0
    load(32'h40404040, 32'hC0C0C0C0, 32'h01010101, 32'hFC03FE01, 32'h40404040);
    sbq.push_back('{0, 16'h7fff, 16'h7fff});
    sbq.push_back('{1, 16'h8000, 16'h0000});
    sbq.push_back('{2, 16'h0400, 16'h0400});
    sbq.push_back('{3, 16'hfe00, 16'h0000});
    out_ready = 1'b0;
    done_cnt = 0;
    pulse_start();
    begin
      int n = 0;
      while (!out_valid_a && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("stall_reach_out", out_valid_a, 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", out_valid_a, 64'd1);
      check("stall_data", out_data_a, 64'h7fff);
      check("stall_idx", out_idx_a, 64'd0);
      check("stall_no_fetch", mem_rd_en_a, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_fetch_rd", mem_rd_en_a, 64'd1);
    check("resume_fetch_waddr", w_addr_a, 64'd4);
    check("resume_fetch_xaddr", x_addr_a, 64'd0);
    wait_done(300);
    check("t2_sb_empty", 64'(sbq.size()), 64'd0);

    // reset during the third fetch cycle, then a clean rerun
    load(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    done_cnt = 0;
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    reset_checks("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("held_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    load(32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202, 32'h01010101);
    for (int i = 0; i < 4; i++) sbq.push_back('{i, 16'd32, 16'd32});
    done_cnt = 0;
    pulse_start();
    wait_done(200);
    check("t4_sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
